// File: rtl/ide_pio_sequencer_if.sv
// rtl/ide_pio_sequencer_if.sv - 68000-side bus and IDE strobe bundle for the PIO sequencer
interface ide_pio_sequencer_if;
  logic AS_n;
  logic RW;
  logic ide_sel;
  logic IORDY;
  logic IOR_n;
  logic IOW_n;
  logic DTACK_n;
  logic busy;
  logic timeout_err;

  modport master (
    output AS_n, RW, ide_sel, IORDY,
    input  IOR_n, IOW_n, DTACK_n, busy, timeout_err
  );

  modport slave (
    input  AS_n, RW, ide_sel, IORDY,
    output IOR_n, IOW_n, DTACK_n, busy, timeout_err
  );
endinterface

// File: rtl/ide_pio_sequencer.sv
// rtl/ide_pio_sequencer.sv - IDE PIO register cycle sequencer (setup/active/recovery, IORDY, DTACK)
module ide_pio_sequencer #(
  parameter int SETUP_CLKS    = 1,
  parameter int ACTIVE_CLKS   = 3,
  parameter int RECOVERY_CLKS = 2,
  parameter int IORDY_TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  ide_pio_sequencer_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_RDY, ACK, RECOVER} state_t;

  state_t     state;
  state_t     next_state;
  state_t     start_state;
  state_t     end_state;
  logic [3:0] cnt;
  logic [7:0] wait_cnt;
  logic       rw_l;
  logic       tmo_hit;
  logic       tmo_next;
  logic       accept;
  logic       req;
  logic       in_xfer;
  logic       stay_xfer;
  logic       strobe_on;

  assign req      = !bus.AS_n && bus.ide_sel;
  assign bus.busy = (state != IDLE);

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    tmo_next    = 1'b0;
    start_state = (SETUP_CLKS == 0) ? STROBE : SETUP;
    end_state   = (RECOVERY_CLKS == 0) ? IDLE : RECOVER;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = start_state;
          accept     = 1'b1;
        end
      end
      SETUP: begin
        if (bus.AS_n)
          next_state = end_state;
        else if (cnt == 4'(SETUP_CLKS - 1))
          next_state = STROBE;
      end
      STROBE: begin
        if (bus.AS_n)
          next_state = end_state;
        else if (cnt == 4'(ACTIVE_CLKS - 1))
          next_state = bus.IORDY ? ACK : WAIT_RDY;
      end
      WAIT_RDY: begin
        if (bus.AS_n)
          next_state = end_state;
        else if (bus.IORDY)
          next_state = ACK;
        else if (wait_cnt == 8'(IORDY_TIMEOUT - 1)) begin
          next_state = ACK;
          tmo_next   = 1'b1;
        end
      end
      ACK: begin
        if (bus.AS_n)
          next_state = end_state;
      end
      RECOVER: begin
        // A request still pending when recovery ends is taken on that same edge
        if (cnt == 4'(RECOVERY_CLKS - 1)) begin
          if (req) begin
            next_state = start_state;
            accept     = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes assert one edge after entering STROBE but drop on the edge that leaves the transfer
  always_comb begin
    in_xfer   = (state == STROBE) || (state == WAIT_RDY) || (state == ACK);
    stay_xfer = (next_state == STROBE) || (next_state == WAIT_RDY) || (next_state == ACK);
    strobe_on = in_xfer && stay_xfer && (rw_l || (state != ACK));
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      wait_cnt        <= 8'd0;
      rw_l            <= 1'b0;
      tmo_hit         <= 1'b0;
      bus.IOR_n       <= 1'b1;
      bus.IOW_n       <= 1'b1;
      bus.DTACK_n     <= 1'b1;
      bus.timeout_err <= 1'b0;
    end else begin
      state <= next_state;
      if (accept)
        rw_l <= bus.RW;
      if ((next_state != state) || accept)
        cnt <= 4'd0;
      else if (cnt != 4'hF)
        cnt <= cnt + 4'd1;
      if ((state == WAIT_RDY) && (next_state == WAIT_RDY)) begin
        if (wait_cnt != 8'hFF)
          wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
      tmo_hit         <= tmo_next;
      bus.timeout_err <= tmo_hit;
      bus.IOR_n       <= !(strobe_on && rw_l);
      bus.IOW_n       <= !(strobe_on && !rw_l);
      bus.DTACK_n     <= !((state == ACK) && (next_state == ACK));
    end
  end
endmodule

// File: tb/tb_ide_pio_sequencer.sv
// tb/tb_ide_pio_sequencer.sv - bench for ide_pio_sequencer: default and minimum-timing instances
module tb_ide_pio_sequencer;
  localparam int NT = 256;

  int p_s [2] = '{1, 0};
  int p_a [2] = '{3, 1};
  int p_r [2] = '{2, 0};
  int p_t [2] = '{64, 3};

  logic CLK = 1'b0;
  logic RESET_n = 1'b0;
  logic as_n = 1'b1;
  logic rw = 1'b1;
  logic ide_sel = 1'b0;
  logic iordy = 1'b1;

  always #5 CLK = ~CLK;

  ide_pio_sequencer_if b0();
  ide_pio_sequencer_if b1();

  assign b0.AS_n = as_n;
  assign b0.RW = rw;
  assign b0.ide_sel = ide_sel;
  assign b0.IORDY = iordy;
  assign b1.AS_n = as_n;
  assign b1.RW = rw;
  assign b1.ide_sel = ide_sel;
  assign b1.IORDY = iordy;

  ide_pio_sequencer u_dut0 (.CLK(CLK), .RESET_n(RESET_n), .bus(b0.slave));

  ide_pio_sequencer #(
    .SETUP_CLKS(0), .ACTIVE_CLKS(1), .RECOVERY_CLKS(0), .IORDY_TIMEOUT(3)
  ) u_dut1 (.CLK(CLK), .RESET_n(RESET_n), .bus(b1.slave));

  logic       s_as  [NT];
  logic       s_sel [NT];
  logic       s_rw  [NT];
  logic       s_rdy [NT];
  // {IOR_n, IOW_n, DTACK_n, busy, timeout_err} after each edge
  logic [4:0] obs  [2][NT];
  logic [4:0] expv [2][NT];
  int checks = 0;
  int failures = 0;

  task automatic clear_stim();
    for (int i = 0; i < NT; i++) begin
      s_as[i] = 1'b1; s_sel[i] = 1'b0; s_rw[i] = 1'b1; s_rdy[i] = 1'b1;
    end
  endtask

  task automatic set_req(input int from, input int to, input logic sel, input logic r);
    for (int i = from; i < to && i < NT; i++) begin
      s_as[i] = 1'b0; s_sel[i] = sel; s_rw[i] = r;
    end
  endtask

  task automatic set_rdy_low(input int from, input int to);
    for (int i = from; i < to && i < NT; i++) s_rdy[i] = 1'b0;
  endtask

  // Transaction-level reference: find accepts, then place each output window by edge arithmetic
  task automatic build_model(input int n);
    int ps, pa, pr, pt, t, free, e0, a, base, k, w, dabs, se;
    logic rd, tout, ab;
    for (int d = 0; d < 2; d++) begin
      ps = p_s[d]; pa = p_a[d]; pr = p_r[d]; pt = p_t[d];
      for (int u = 0; u < NT; u++) expv[d][u] = 5'b11100;
      free = 0; t = 0;
      while (t < n) begin
        if (t >= free && !s_as[t] && s_sel[t]) begin
          e0 = t; rd = s_rw[t];
          a = e0 + 1;
          while (a < n && !s_as[a]) a++;
          base = e0 + ps + pa;
          k = base;
          while (k < n && !s_rdy[k]) k++;
          w = k - base;
          tout = (w > pt);
          dabs = base + 1 + (tout ? pt : w);
          ab = (a <= dabs - 1);
          for (int u = e0; u < a + pr && u < n; u++) expv[d][u][1] = 1'b1;
          se = ab ? a : (rd ? a : dabs);
          for (int u = e0 + ps + 1; u < se && u < n; u++) begin
            if (rd) expv[d][u][4] = 1'b0;
            else    expv[d][u][3] = 1'b0;
          end
          if (!ab) begin
            for (int u = dabs; u < a && u < n; u++) expv[d][u][2] = 1'b0;
            if (tout && dabs < n) expv[d][dabs][0] = 1'b1;
          end
          free = a + pr;
          t = free;
        end else begin
          t++;
        end
      end
    end
  endtask

  task automatic run_timeline(input int n);
    build_model(n);
    for (int t = 0; t < n; t++) begin
      as_n = s_as[t]; ide_sel = s_sel[t]; rw = s_rw[t]; iordy = s_rdy[t];
      @(posedge CLK);
      @(negedge CLK);
      obs[0][t] = {b0.IOR_n, b0.IOW_n, b0.DTACK_n, b0.busy, b0.timeout_err};
      obs[1][t] = {b1.IOR_n, b1.IOW_n, b1.DTACK_n, b1.busy, b1.timeout_err};
    end
    as_n = 1'b1; ide_sel = 1'b0; iordy = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if ({b0.IOR_n, b0.IOW_n, b0.DTACK_n, b0.busy, b0.timeout_err} !== 5'b11100) begin
      failures++;
      $display("FAIL reset_dut0 got=%b exp=11100", {b0.IOR_n, b0.IOW_n, b0.DTACK_n, b0.busy, b0.timeout_err});
    end
    checks++;
    if ({b1.IOR_n, b1.IOW_n, b1.DTACK_n, b1.busy, b1.timeout_err} !== 5'b11100) begin
      failures++;
      $display("FAIL reset_dut1 got=%b exp=11100", {b1.IOR_n, b1.IOW_n, b1.DTACK_n, b1.busy, b1.timeout_err});
    end
    RESET_n = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (b0.busy !== 1'b0 || b1.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b%b exp=00", b0.busy, b1.busy);
    end
  endtask

  task automatic test_read();
    clear_stim();
    set_req(2, 10, 1'b1, 1'b1);
    run_timeline(20);
    for (int d = 0; d < 2; d++)
      for (int t = 0; t < 20; t++) begin
        checks++;
        if (obs[d][t] !== expv[d][t]) begin
          failures++;
          $display("FAIL read_timeline dut%0d t=%0d got=%b exp=%b", d, t, obs[d][t], expv[d][t]);
        end
      end
    checks++;
    if (obs[0][3][4] !== 1'b1 || obs[0][4][4] !== 1'b0 || obs[0][9][4] !== 1'b0 || obs[0][10][4] !== 1'b1) begin
      failures++;
      $display("FAIL read_ior_window got=%b%b%b%b exp=1001", obs[0][3][4], obs[0][4][4], obs[0][9][4], obs[0][10][4]);
    end
    checks++;
    if (obs[0][6][2] !== 1'b1 || obs[0][7][2] !== 1'b0 || obs[0][10][2] !== 1'b1) begin
      failures++;
      $display("FAIL read_dtack got=%b%b%b exp=101", obs[0][6][2], obs[0][7][2], obs[0][10][2]);
    end
    checks++;
    if (obs[0][11][1] !== 1'b1 || obs[0][12][1] !== 1'b0) begin
      failures++;
      $display("FAIL read_busy_release got=%b%b exp=10", obs[0][11][1], obs[0][12][1]);
    end
  endtask

  task automatic test_write();
    clear_stim();
    set_req(2, 10, 1'b1, 1'b0);
    run_timeline(20);
    for (int d = 0; d < 2; d++)
      for (int t = 0; t < 20; t++) begin
        checks++;
        if (obs[d][t] !== expv[d][t]) begin
          failures++;
          $display("FAIL write_timeline dut%0d t=%0d got=%b exp=%b", d, t, obs[d][t], expv[d][t]);
        end
      end
    for (int t = 4; t <= 6; t++) begin
      checks++;
      if (obs[0][t][3] !== 1'b0) begin
        failures++;
        $display("FAIL write_iow_low t=%0d got=%b exp=0", t, obs[0][t][3]);
      end
    end
    checks++;
    if (obs[0][7][3] !== 1'b1 || obs[0][7][2] !== 1'b0 || obs[0][6][2] !== 1'b1) begin
      failures++;
      $display("FAIL write_ack_edge got iow=%b dtack=%b prev_dtack=%b exp=1,0,1", obs[0][7][3], obs[0][7][2], obs[0][6][2]);
    end
  endtask

  task automatic test_iordy_stretch();
    int pulses;
    clear_stim();
    set_req(2, 16, 1'b1, 1'b1);
    set_rdy_low(3, 11);
    run_timeline(24);
    pulses = 0;
    for (int d = 0; d < 2; d++)
      for (int t = 0; t < 24; t++) begin
        checks++;
        if (obs[d][t] !== expv[d][t]) begin
          failures++;
          $display("FAIL stretch_timeline dut%0d t=%0d got=%b exp=%b", d, t, obs[d][t], expv[d][t]);
        end
      end
    for (int t = 0; t < 24; t++) if (obs[0][t][0] === 1'b1) pulses++;
    checks++;
    if (obs[0][11][2] !== 1'b1 || obs[0][12][2] !== 1'b0 || obs[0][11][4] !== 1'b0) begin
      failures++;
      $display("FAIL stretch_dtack got=%b%b ior=%b exp=10 ior=0", obs[0][11][2], obs[0][12][2], obs[0][11][4]);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL stretch_no_timeout got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    clear_stim();
    set_req(2, 77, 1'b1, 1'b1);
    set_rdy_low(3, 77);
    run_timeline(90);
    pulses = 0;
    for (int d = 0; d < 2; d++)
      for (int t = 0; t < 90; t++) begin
        checks++;
        if (obs[d][t] !== expv[d][t]) begin
          failures++;
          $display("FAIL timeout_timeline dut%0d t=%0d got=%b exp=%b", d, t, obs[d][t], expv[d][t]);
        end
      end
    for (int t = 0; t < 90; t++) if (obs[0][t][0] === 1'b1) pulses++;
    checks++;
    if (obs[0][70][0] !== 1'b0 || obs[0][71][0] !== 1'b1 || pulses != 1) begin
      failures++;
      $display("FAIL timeout_pulse got=%b%b count=%0d exp=01 count=1", obs[0][70][0], obs[0][71][0], pulses);
    end
    checks++;
    if (obs[0][70][2] !== 1'b1 || obs[0][71][2] !== 1'b0) begin
      failures++;
      $display("FAIL timeout_dtack got=%b%b exp=10", obs[0][70][2], obs[0][71][2]);
    end
  endtask

  task automatic test_abort_back_to_back();
    int dt_low;
    clear_stim();
    set_req(2, 5, 1'b1, 1'b1);
    set_req(6, 16, 1'b1, 1'b1);
    run_timeline(28);
    for (int d = 0; d < 2; d++)
      for (int t = 0; t < 28; t++) begin
        checks++;
        if (obs[d][t] !== expv[d][t]) begin
          failures++;
          $display("FAIL b2b_timeline dut%0d t=%0d got=%b exp=%b", d, t, obs[d][t], expv[d][t]);
        end
      end
    dt_low = 0;
    for (int t = 0; t < 12; t++) if (obs[0][t][2] !== 1'b1) dt_low++;
    checks++;
    if (obs[0][4][4] !== 1'b0 || obs[0][5][4] !== 1'b1 || dt_low != 0) begin
      failures++;
      $display("FAIL abort_release got ior=%b%b dtack_low=%0d exp ior=01 dtack_low=0", obs[0][4][4], obs[0][5][4], dt_low);
    end
    checks++;
    if (obs[0][8][4] !== 1'b1 || obs[0][9][4] !== 1'b0 || obs[0][12][2] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got ior=%b%b dtack=%b exp ior=10 dtack=0", obs[0][8][4], obs[0][9][4], obs[0][12][2]);
    end
  endtask

  task automatic test_random();
    int t, h, lo, ln;
    for (int it = 0; it < 3; it++) begin
      clear_stim();
      t = 1;
      while (t < NT - 40) begin
        t += $urandom_range(1, 4);
        h = $urandom_range(1, 14);
        set_req(t, t + h, ($urandom_range(0, 5) != 0), $urandom_range(0, 1) == 1);
        if ($urandom_range(0, 1) == 1) begin
          lo = t + $urandom_range(0, 5);
          ln = $urandom_range(0, 9);
          set_rdy_low(lo, lo + ln);
        end
        t += h;
      end
      run_timeline(NT);
      for (int d = 0; d < 2; d++)
        for (int u = 0; u < NT; u++) begin
          checks++;
          if (obs[d][u] !== expv[d][u]) begin
            failures++;
            $display("FAIL random_timeline it=%0d dut%0d t=%0d got=%b exp=%b", it, d, u, obs[d][u], expv[d][u]);
          end
        end
    end
  endtask

  task automatic test_reset_mid_strobe();
    @(negedge CLK);
    as_n = 1'b0; ide_sel = 1'b1; rw = 1'b1; iordy = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    checks++;
    if (b0.IOR_n !== 1'b0) begin
      failures++;
      $display("FAIL mid_strobe_active got=%b exp=0", b0.IOR_n);
    end
    #2 RESET_n = 1'b0;
    #1;
    checks++;
    if ({b0.IOR_n, b0.IOW_n, b0.DTACK_n, b0.busy, b0.timeout_err} !== 5'b11100) begin
      failures++;
      $display("FAIL async_reset_dut0 got=%b exp=11100", {b0.IOR_n, b0.IOW_n, b0.DTACK_n, b0.busy, b0.timeout_err});
    end
    checks++;
    if ({b1.IOR_n, b1.IOW_n, b1.DTACK_n, b1.busy, b1.timeout_err} !== 5'b11100) begin
      failures++;
      $display("FAIL async_reset_dut1 got=%b exp=11100", {b1.IOR_n, b1.IOW_n, b1.DTACK_n, b1.busy, b1.timeout_err});
    end
    as_n = 1'b1; ide_sel = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESET_n = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    test_read();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_iordy_stretch();
    test_timeout();
    test_abort_back_to_back();
    test_random();
    test_reset_mid_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ide_pio_sequencer.md
Name: ide_pio_sequencer

Overview:
Sequences IDE PIO register accesses from the 68000-side bus cycle. It generates IOR_n/IOW_n with programmable setup, active and recovery timing, honours drive IORDY with a timeout, and generates DTACK_n for IDE register cycles. It sits between the Zorro-side address decode (ide_sel) and the IDE drive strobes. All timing is counted in CLK cycles, where CLK is the CPU bus clock.

Parameters:
SETUP_CLKS, 1, clocks between request acceptance and strobe assertion (address/CS setup); legal range 0..15
ACTIVE_CLKS, 3, minimum strobe-low width in clocks; legal range 1..15
RECOVERY_CLKS, 2, idle clocks after a cycle ends before the next request is accepted; legal range 0..15
IORDY_TIMEOUT, 64, maximum extra clocks spent waiting for IORDY; legal range 1..255

Ports:
CLK  input  1  bus clock
RESET_n  input  1  asynchronous active-low reset
AS_n  input  1  68000 address strobe, synchronous to CLK
RW  input  1  1 = read, 0 = write; valid while AS_n is low
ide_sel  input  1  decoded IDE task-file access; valid while AS_n is low
IORDY  input  1  drive ready; low = stretch
IOR_n  output  1  IDE read strobe, registered
IOW_n  output  1  IDE write strobe, registered
DTACK_n  output  1  data acknowledge, registered; board logic handles tristate
busy  output  1  high in any state other than IDLE
timeout_err  output  1  one-clock pulse when the IORDY wait times out

Behaviour:
- Reset (asynchronous): state=IDLE; IOR_n=1, IOW_n=1, DTACK_n=1, busy=0, timeout_err=0; all counters=0. Reset mid-cycle releases the strobes and DTACK_n immediately.
- All transitions occur on the rising edge of CLK. The cycle's direction is latched from RW at acceptance (rw_l).
- IDLE: a request is accepted at the edge E0 where AS_n=0 and ide_sel=1. Next state is SETUP, or STROBE if SETUP_CLKS=0.
- SETUP: held for SETUP_CLKS clocks. Both strobes stay high.
- STROBE: IOR_n=0 if rw_l=1, otherwise IOW_n=0.
  - Strobe goes low at edge E0+SETUP_CLKS+1.
  - Held for ACTIVE_CLKS clocks.
  - At expiry, IORDY=1 goes to ACK; IORDY=0 goes to WAIT_RDY.
- WAIT_RDY: strobe stays asserted and the wait counter increments each clock.
  - IORDY=1 goes to ACK.
  - If the counter reaches IORDY_TIMEOUT: pulse timeout_err for 1 clock, then go to ACK. The access completes and is not hung.
- ACK: DTACK_n=0.
  - Reads keep IOR_n=0 so drive data stays valid while the CPU samples.
  - Writes release IOW_n at ACK entry; write data is held by the CPU until AS_n rises.
  - AS_n=1 goes to RECOVER. IOR_n and DTACK_n return to 1 on that edge.
- RECOVER: strobes high and DTACK_n=1 for RECOVERY_CLKS clocks, then IDLE. If RECOVERY_CLKS=0, go straight to IDLE.
- Latency with no IORDY stretch: DTACK_n low at E0+SETUP_CLKS+ACTIVE_CLKS+1. With defaults, strobe low at E0+2 and DTACK_n low at E0+5.
- Abort: if AS_n=1 in SETUP, STROBE or WAIT_RDY (external bus timeout), go to RECOVER on that edge. Strobes release and DTACK_n is never asserted.
- Requests during SETUP..RECOVER are not queued. A request still present (AS_n=0, ide_sel=1) when IDLE is re-entered is accepted then, which delays its DTACK.
- A new AS_n assertion is only evaluated in IDLE. An AS_n low carried over from the same bus cycle cannot retrigger, because ACK waits for AS_n=1.
- IOR_n and IOW_n are never low in the same clock.
- Counters are 4-bit, plus an 8-bit wait counter. Counters saturate and never wrap.
- ide_sel=0 cycles are ignored and DTACK_n stays 1.

Test Plan:
1. Defaults, read: AS_n low with ide_sel=1, RW=1, IORDY=1 at E0 -> IOR_n low at E0+2 through AS_n rise; DTACK_n low at E0+5; IOR_n and DTACK_n high on the edge AS_n is seen high; busy low 2 clocks later.
2. Defaults, write: RW=0 -> IOW_n low at E0+2..E0+4 (3 clocks); DTACK_n low at E0+5; IOW_n high at E0+5.
3. IORDY stretch: IORDY held low until E0+9 -> strobe held; DTACK_n low at E0+10; timeout_err stays 0.
4. Timeout: IORDY held low permanently -> timeout_err pulses once at E0+5+64; DTACK_n low on the same edge.
5. Abort and back-to-back:
   - AS_n rises at E0+3 -> IOR_n high at E0+3 and DTACK_n never low.
   - A new request held low from E0+4 is accepted at E0+5 (IDLE), with strobe low at E0+7.
6. Reset mid-strobe: RESET_n low during STROBE -> IOR_n, IOW_n and DTACK_n at 1 immediately and busy=0. After release, the next request follows scenario 1 timing.
